// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// -----------------------------------------------------------------------------
// Memory-mapped console transmitter. It sits on the execute-stage data-memory
// port in parallel with the data RAM.
//   - Byte writes to BASE_ADDR are queued in a small FIFO.
//   - The queued bytes are serialized as 8N1 frames on txd, LSB first.
//   - A status word at BASE_ADDR+4 lets software poll before writing.
//   - Writing 1 to status bit 2 clears the sticky overflow flag.
//
// Optional feature:
//   MMIO_UART_TX_PARITY_EN (define to enable)
//     Adds an even-parity bit between the data bits and the stop bit.
//     This makes each frame 11 bit-times long. Status bit 3 reads 1.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous reset, active-high
//   addr     in  32  data-memory address from execute
//   width    in   2  access width (ignored, any width accepted)
//   write    in   1  data-memory write strobe
//   din      in  32  write data (din[7:0] = TX byte, din[2] = overflow clear)
//   dout     out 32  status word when addr == BASE_ADDR+4, else 0
//   txd      out  1  serial output, idle high
//   tx_busy  out  1  high while the FIFO is non-empty or a frame is in flight
//
// Status word:
//   [0]     tx_idle
//   [1]     fifo_full
//   [2]     overflow
//   [3]     parity enabled
//   [15:8]  fifo count
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR       = 32'h000F0000,
  parameter int          CLKS_PER_BIT    = 4,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic        write,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        txd,
  output logic        tx_busy
);

  localparam int                   DEPTH      = 1 << FIFO_DEPTH_LOG2;
  localparam int                   CW         = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]        FULL_COUNT = CW'(DEPTH);
  localparam logic [15:0]          BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0]          STAT_ADDR  = BASE_ADDR + 32'd4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic       PARITY_FLAG = 1'b1;
`else
  localparam logic       PARITY_FLAG = 1'b0;
`endif

  // The access width is ignored.
  // Only the low byte of din is stored, so the upper din bits are unused.
  logic unused_inputs;
  assign unused_inputs = ^{width, din[31:8]};

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [2:0]                 state_q, state_d;
  logic [15:0]                baud_q, baud_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       txd_q, txd_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  logic       push_hit, status_hit, clear_ovf;
  logic       fifo_full, fifo_empty, push, drop, pop;
  logic       baud_last, tx_idle;
  logic [7:0] fifo_head;

  assign push_hit   = write && (addr == BASE_ADDR);
  assign status_hit = (addr == STAT_ADDR);
  assign clear_ovf  = write && status_hit && din[2];

  // "Full" is judged on the registered count, before any same-cycle pop.
  // A write to a full FIFO is therefore dropped even if a pop happens too.
  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);
  assign push       = push_hit && !fifo_full;
  assign drop       = push_hit && fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign baud_last  = (baud_q == BAUD_LAST);

  assign tx_idle = fifo_empty && (state_q == ST_IDLE);
  assign tx_busy = !tx_idle;
  assign txd     = txd_q;

  // Serializer next-state logic.
  // Pops are decided from the registered count. A byte pushed into an
  // empty FIFO therefore waits one cycle before it can be popped.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef MMIO_UART_TX_PARITY_EN
          parity_d = ^fifo_head;
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
`ifdef MMIO_UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      ST_STOP: begin
        // On the last stop cycle, a waiting byte is popped.
        // This starts the next frame with no idle gap.
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_d = ^fifo_head;
`endif
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // The line level is registered from the current state.
  // As a result, txd trails the state register by one cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // FIFO pointer, count and overflow bookkeeping.
  // If a drop and a clear land in the same cycle, the overflow set wins.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (clear_ovf) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;
  end

  // Status read port.
  always_comb begin
    dout = '0;
    if (status_hit) begin
      dout[0]    = tx_idle;
      dout[1]    = fifo_full;
      dout[2]    = overflow_q;
      dout[3]    = PARITY_FLAG;
      dout[15:8] = 8'(count_q);
    end
  end

  // FIFO storage needs no reset.
  // An empty count makes any stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= din[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
`ifdef MMIO_UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// -----------------------------------------------------------------------------
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and a 16-entry FIFO.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h000F0000;
  localparam logic [31:0] STAT = 32'h000F0004;
  localparam int          CPB  = 4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic [31:0] PFLAG      = 32'h8;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic [31:0] PFLAG      = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [1:0]  width = 2'b10;
  logic        write = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        txd;
  logic        tx_busy;

  int vectors = 0;
  int miscompares = 0;

  mmio_uart_tx #(
    .BASE_ADDR      (BASE),
    .CLKS_PER_BIT   (CPB),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .width  (width),
    .write  (write),
    .din    (din),
    .dout   (dout),
    .txd    (txd),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One-cycle bus write, captured on the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    din   = d;
    write = 1'b1;
    tick();
    write = 1'b0;
    addr  = '0;
    din   = '0;
  endtask

  task automatic readStatus(output logic [31:0] value);
    addr = STAT;
    #1;
    value = dout;
  endtask

  task automatic doReset();
    write = 1'b0;
    addr  = '0;
    din   = '0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Entered on the first start-bit sample.
  // Samples each bit at mid-bit.
  // Returns on the last stop-bit sample.
  task automatic recvFrame(output logic [7:0] data, output logic busy_mid_stop);
    data = '0;
    repeat (CPB / 2) tick();
    checkOutput("start_bit", {31'b0, txd}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      data[i] = txd;
    end
`ifdef MMIO_UART_TX_PARITY_EN
    repeat (CPB) tick();
    checkOutput("parity_bit", {31'b0, txd}, {31'b0, ^data});
`endif
    repeat (CPB) tick();
    checkOutput("stop_bit", {31'b0, txd}, 32'd1);
    busy_mid_stop = tx_busy;
    repeat (CPB - CPB / 2 - 1) tick();
  endtask

  initial begin
    logic [31:0] st;
    logic [7:0]  rx;
    logic        busy;
    int          noisy;

    $display("[TB] starting mmio_uart_tx directed test");

    // Reset values.
    tick();
    readStatus(st);
    checkOutput("rst_txd", {31'b0, txd}, 32'd1);
    checkOutput("rst_busy", {31'b0, tx_busy}, 32'd0);
    checkOutput("rst_status", st, 32'h1 | PFLAG);
    addr = BASE;
    #1;
    checkOutput("dout_unselected", dout, 32'd0);
    addr = '0;
    rst = 1'b0;
    tick();

    // Single byte 0x41: txd falls two edges after the write.
    applyStimulus(BASE, 32'h41);
    checkOutput("lat_txd_n0", {31'b0, txd}, 32'd1);
    tick();
    checkOutput("lat_txd_n1", {31'b0, txd}, 32'd1);
    tick();
    checkOutput("lat_txd_n2", {31'b0, txd}, 32'd0);
    recvFrame(rx, busy);
    checkOutput("byte_0x41", {24'b0, rx}, 32'h41);
    checkOutput("busy_last_stop", {31'b0, busy}, 32'd1);
    checkOutput("busy_drop", {31'b0, tx_busy}, 32'd0);
    tick();
    checkOutput("idle_txd", {31'b0, txd}, 32'd1);

    // Back-to-back bytes 0x48, 0x69.
    applyStimulus(BASE, 32'h48);
    applyStimulus(BASE, 32'h69);
    readStatus(st);
    checkOutput("b2b_count", st, 32'h0100 | PFLAG);
    tick();
    recvFrame(rx, busy);
    checkOutput("byte_0x48", {24'b0, rx}, 32'h48);
    tick();
    checkOutput("no_gap_start", {31'b0, txd}, 32'd0);
    recvFrame(rx, busy);
    checkOutput("byte_0x69", {24'b0, rx}, 32'h69);
    tick();
    checkOutput("b2b_end_busy", {31'b0, tx_busy}, 32'd0);
    checkOutput("b2b_end_txd", {31'b0, txd}, 32'd1);

    // Fill: 17 writes, overflow, clear, then drain check.
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(BASE, i);
    readStatus(st);
    checkOutput("fill_status", st, 32'h1002 | PFLAG);
    applyStimulus(BASE, 32'hAA);
    readStatus(st);
    checkOutput("ovf_status", st, 32'h1006 | PFLAG);
    applyStimulus(STAT, 32'h4);
    readStatus(st);
    checkOutput("ovf_clear", st, 32'h1002 | PFLAG);
    repeat (CPB * FRAME_BITS - 16) tick();
    checkOutput("fill_next_start", {31'b0, txd}, 32'd0);
    recvFrame(rx, busy);
    checkOutput("fill_byte_01", {24'b0, rx}, 32'h01);
    readStatus(st);
    checkOutput("drain_status", st, 32'h0E00 | PFLAG);
    tick();
    recvFrame(rx, busy);
    checkOutput("fill_byte_02", {24'b0, rx}, 32'h02);

    // Reset in the middle of data bit 3, with 5 bytes still queued.
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(BASE, 32'h55 + i);
    repeat (15) tick();
    checkOutput("pre_rst_busy", {31'b0, tx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    readStatus(st);
    checkOutput("midrst_txd", {31'b0, txd}, 32'd1);
    checkOutput("midrst_status", st, 32'h1 | PFLAG);
    checkOutput("midrst_busy", {31'b0, tx_busy}, 32'd0);
    tick();
    rst = 1'b0;
    noisy = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (txd !== 1'b1) noisy++;
    end
    checkOutput("post_rst_silent", noisy, 32'd0);

    // Byte 0x07 exercises the parity bit when that feature is built in.
    applyStimulus(BASE, 32'h07);
    tick();
    tick();
    recvFrame(rx, busy);
    checkOutput("byte_0x07", {24'b0, rx}, 32'h07);
    readStatus(st);
    checkOutput("parity_flag", st & 32'h8, PFLAG);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
